// File: rtl/iic_slave_core.sv
// iic_slave_core
//   I2C slave byte engine (7-bit address SADDR). Oversamples SCL/SDA with
//   i_clk (at least 16x SCL), acknowledges its address, receives an
//   unlimited stream of write bytes, and returns bytes on read until the
//   master NACKs. Partial bytes are discarded on START/STOP.
// Ports
//   i_clk, i_rst    : system clock, synchronous active-high reset
//   i_i2c_scl/sda   : bus pin levels (asynchronous)
//   o_i2c_sda_oe    : 1 = pull SDA low, 0 = release
//   o_rx_data/valid : received byte and its one-cycle strobe
//   i_tx_data       : byte to return on read
//   o_tx_req        : one-cycle strobe, i_tx_data captured
//   o_i2c_busy      : high while this slave is addressed
module iic_slave_core #(
  parameter logic [6:0] SADDR = 7'h27
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_i2c_scl,
  input  logic       i_i2c_sda,
  output logic       o_i2c_sda_oe,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
  output logic       o_i2c_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_WRITE, S_ACK_WRITE, S_READ, S_ACK_READ, S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        scl_meta_q, scl_sync_q, scl_hist_q;
  logic        sda_meta_q, sda_sync_q, sda_hist_q;
  logic [3:0]  cnt_q;
  logic        bit9_q;    // ninth (acknowledge) SCL rise already seen
  logic        rw_q;
  logic        nack_q;
  logic        oe_q;
  logic        rx_valid_q;
  logic        tx_req_q;
  logic [7:0]  rx_data_q;
  logic [7:0]  shift_q;

  logic        scl_rise, scl_fall, start_det, stop_det, last_bit, tx_load;
  logic [7:0]  byte_in;

  // Synchronizer stage: two metastability flops plus one history flop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= i_i2c_scl;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= i_i2c_sda;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  // START/STOP need SCL high in both samples so an SCL edge is never mistaken
  // for a bus condition.
  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  assign start_det = scl_sync_q & scl_hist_q & ~sda_sync_q & sda_hist_q;
  assign stop_det  = scl_sync_q & scl_hist_q & sda_sync_q & ~sda_hist_q;
  assign byte_in   = {shift_q[6:0], sda_sync_q};
  assign last_bit  = scl_rise && (cnt_q == 4'd7);
  // End of an acknowledge slot that hands the bus a fresh read byte.
  assign tx_load   = scl_fall && bit9_q &&
                     (((state_q == S_ACK_ADDR) && rw_q) ||
                      ((state_q == S_ACK_READ) && !nack_q));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_ADDR;
    end else begin
      case (state_q)
        S_ADDR:      if (last_bit) state_d = (byte_in[7:1] == SADDR) ? S_ACK_ADDR : S_IGNORE;
        S_ACK_ADDR:  if (scl_fall && bit9_q) state_d = rw_q ? S_READ : S_WRITE;
        S_WRITE:     if (last_bit) state_d = S_ACK_WRITE;
        S_ACK_WRITE: if (scl_fall && bit9_q) state_d = S_WRITE;
        S_READ:      if (scl_fall && (cnt_q == 4'd8)) state_d = S_ACK_READ;
        S_ACK_READ:  if (scl_fall && bit9_q) state_d = nack_q ? S_IGNORE : S_READ;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_i2c_busy = 1'b0;
    case (state_q)
      S_ACK_ADDR, S_WRITE, S_ACK_WRITE, S_READ, S_ACK_READ: o_i2c_busy = 1'b1;
      default: o_i2c_busy = 1'b0;
    endcase
  end

  assign o_i2c_sda_oe = oe_q;
  assign o_rx_data    = rx_data_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_tx_req     = tx_req_q;

  // Control and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q      <= 4'd0;
      bit9_q     <= 1'b0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (stop_det || start_det) begin
        cnt_q  <= 4'd0;
        bit9_q <= 1'b0;
        oe_q   <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise) cnt_q <= cnt_q + 4'd1;
            if (last_bit) rw_q <= sda_sync_q;
          end
          S_ACK_ADDR, S_ACK_WRITE: begin
            if (scl_rise) bit9_q <= 1'b1;
            if (scl_fall) begin
              if (!bit9_q) begin
                oe_q <= 1'b1;
              end else begin
                oe_q   <= 1'b0;
                cnt_q  <= 4'd0;
                bit9_q <= 1'b0;
              end
            end
            if (tx_load) begin
              oe_q     <= ~i_tx_data[7];
              tx_req_q <= 1'b1;
            end
          end
          S_WRITE: begin
            if (scl_rise) cnt_q <= cnt_q + 4'd1;
            if (last_bit) begin
              rx_data_q  <= byte_in;
              rx_valid_q <= 1'b1;
            end
          end
          S_READ: begin
            if (scl_rise && (cnt_q != 4'd8)) cnt_q <= cnt_q + 4'd1;
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                oe_q   <= 1'b0;
                bit9_q <= 1'b0;
              end else begin
                oe_q <= ~shift_q[6];
              end
            end
          end
          S_ACK_READ: begin
            if (scl_rise) begin
              bit9_q <= 1'b1;
              nack_q <= sda_sync_q;
            end
            if (scl_fall && bit9_q) begin
              cnt_q  <= 4'd0;
              bit9_q <= 1'b0;
              oe_q   <= 1'b0;
            end
            if (tx_load) begin
              oe_q     <= ~i_tx_data[7];
              tx_req_q <= 1'b1;
            end
          end
          default: oe_q <= 1'b0;
        endcase
      end
    end
  end

  // Shift register: samples on SCL rise when receiving, shifts on SCL fall
  // when transmitting.
  always_ff @(posedge i_clk) begin
    if (tx_load) begin
      shift_q <= i_tx_data;
    end else if (scl_rise && ((state_q == S_ADDR) || (state_q == S_WRITE))) begin
      shift_q <= byte_in;
    end else if (scl_fall && (state_q == S_READ) && (cnt_q != 4'd8)) begin
      shift_q <= {shift_q[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_iic_slave_core.sv
module tb_iic_slave_core;

  localparam int Q = 8;  // i_clk cycles per SCL quarter period (SCL = clk/32)

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic [7:0] tx_data;
  logic       oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic       bus_sda;

  assign bus_sda = m_sda & ~oe;

  always #5 clk = ~clk;

  iic_slave_core #(.SADDR(7'h27)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_i2c_scl    (m_scl),
    .i_i2c_sda    (bus_sda),
    .o_i2c_sda_oe (oe),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .i_tx_data    (tx_data),
    .o_tx_req     (tx_req),
    .o_i2c_busy   (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int rx_cnt = 0, tx_cnt = 0, oe_cyc = 0, busy_cyc = 0, both_cyc = 0, long_cyc = 0;
  logic [7:0] rx_log [64];
  logic       rx_valid_d = 1'b0, tx_req_d = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[5:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_req)              tx_cnt   <= tx_cnt + 1;
    if (oe)                  oe_cyc   <= oe_cyc + 1;
    if (busy)                busy_cyc <= busy_cyc + 1;
    if (rx_valid && tx_req)  both_cyc <= both_cyc + 1;
    if ((rx_valid && rx_valid_d) || (tx_req && tx_req_d)) long_cyc <= long_cyc + 1;
    rx_valid_d <= rx_valid;
    tx_req_d   <= tx_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic qtr();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic r);
    m_sda = b;
    qtr();
    m_scl = 1'b1;
    qtr();
    r = bus_sda;
    qtr();
    m_scl = 1'b0;
    qtr();
  endtask

  // Returns the bus level on the ninth clock (0 = slave acknowledged).
  task automatic send_byte(input logic [7:0] d, output logic ack_n);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(d[i], r);
    send_bit(1'b1, ack_n);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
    end
    send_bit(~m_ack, r);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; m_scl = 1'b1; qtr();
    m_sda = 1'b0; qtr();
    m_scl = 1'b0; qtr();
  endtask

  task automatic i2c_rep_start();
    m_sda = 1'b1; qtr();
    m_scl = 1'b1; qtr();
    m_sda = 1'b0; qtr();
    m_scl = 1'b0; qtr();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qtr();
    m_scl = 1'b1; qtr();
    m_sda = 1'b1; qtr();
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         b_rx, b_tx, b_oe, b_busy;
    logic [5:0] idx;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_oe",       oe,       1'b0);
    check("rst_rx_data",  rx_data,  8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req",   tx_req,   1'b0);
    check("rst_busy",     busy,     1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single write byte to own address
    b_rx = rx_cnt;
    i2c_start();
    send_byte(8'h4E, ack);
    check("t1_addr_ack", ack,  1'b0);
    check("t1_busy",     busy, 1'b1);
    send_byte(8'hA5, ack);
    check("t1_data_ack", ack, 1'b0);
    check("t1_rx_cnt",   rx_cnt - b_rx, 1);
    check("t1_rx_data",  rx_data, 8'hA5);
    check("t1_busy_pre_stop", busy, 1'b1);
    i2c_stop();
    check("t1_busy_post_stop", busy, 1'b0);

    // Foreign address: never drive, never flag anything
    b_rx = rx_cnt; b_oe = oe_cyc; b_busy = busy_cyc;
    i2c_start();
    send_byte(8'h7E, ack);
    check("t2_addr_nack", ack, 1'b1);
    send_byte(8'h12, ack);
    check("t2_data_nack", ack, 1'b1);
    i2c_stop();
    check("t2_oe_cycles",   oe_cyc - b_oe, 0);
    check("t2_rx_cnt",      rx_cnt - b_rx, 0);
    check("t2_busy_cycles", busy_cyc - b_busy, 0);

    // Three-byte write burst
    b_rx = rx_cnt;
    i2c_start();
    send_byte(8'h4E, ack); check("t3_addr_ack", ack, 1'b0);
    send_byte(8'h08, ack); check("t3_ack0", ack, 1'b0);
    send_byte(8'h0C, ack); check("t3_ack1", ack, 1'b0);
    send_byte(8'h08, ack); check("t3_ack2", ack, 1'b0);
    i2c_stop();
    check("t3_rx_cnt", rx_cnt - b_rx, 3);
    idx = 6'(b_rx);     check("t3_rx0", rx_log[idx], 8'h08);
    idx = 6'(b_rx + 1); check("t3_rx1", rx_log[idx], 8'h0C);
    idx = 6'(b_rx + 2); check("t3_rx2", rx_log[idx], 8'h08);

    // Read two bytes, ACK then NACK, then an ignored byte
    b_tx = tx_cnt;
    tx_data = 8'h5A;
    i2c_start();
    send_byte(8'h4F, ack);
    check("t4_addr_ack", ack, 1'b0);
    check("t4_tx_req0",  tx_cnt - b_tx, 1);
    tx_data = 8'hC3;
    read_byte(1'b1, d);
    check("t4_byte0",   d, 8'h5A);
    check("t4_tx_req1", tx_cnt - b_tx, 2);
    read_byte(1'b0, d);
    check("t4_byte1",   d, 8'hC3);
    check("t4_oe_released", oe, 1'b0);
    check("t4_tx_req_after_nack", tx_cnt - b_tx, 2);
    b_oe = oe_cyc;
    send_byte(8'hFF, ack);
    check("t4_ignore_ack", ack, 1'b1);
    check("t4_ignore_oe",  oe_cyc - b_oe, 0);
    i2c_stop();
    check("t4_busy_post_stop", busy, 1'b0);

    // Partial byte discarded by repeated START
    b_rx = rx_cnt;
    i2c_start();
    send_byte(8'h4E, ack); check("t5_addr_ack0", ack, 1'b0);
    send_bit(1'b1, ack); send_bit(1'b0, ack); send_bit(1'b1, ack); send_bit(1'b0, ack);
    i2c_rep_start();
    send_byte(8'h4E, ack); check("t5_addr_ack1", ack, 1'b0);
    send_byte(8'h33, ack); check("t5_data_ack",  ack, 1'b0);
    i2c_stop();
    check("t5_rx_cnt",  rx_cnt - b_rx, 1);
    check("t5_rx_data", rx_data, 8'h33);

    // Reset pulse in the middle of the address acknowledge
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h4E;
      send_bit(d[i], ack);
    end
    m_sda = 1'b1;
    qtr();
    check("t6_ack_driving", oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_oe_after_rst",   oe,   1'b0);
    check("t6_busy_after_rst", busy, 1'b0);
    m_scl = 1'b1; qtr(); qtr();
    m_scl = 1'b0; qtr();
    b_rx = rx_cnt;
    send_byte(8'h55, ack);
    check("t6_no_data_ack", ack, 1'b1);
    i2c_stop();
    check("t6_rx_cnt", rx_cnt - b_rx, 0);
    i2c_start();
    send_byte(8'h4E, ack); check("t6_recover_addr_ack", ack, 1'b0);
    send_byte(8'h9C, ack); check("t6_recover_data_ack", ack, 1'b0);
    i2c_stop();
    check("t6_recover_rx_data", rx_data, 8'h9C);

    check("strobe_overlap", both_cyc, 0);
    check("strobe_width",   long_cyc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
